// File: rtl/energy_cmd_rx.sv
// UART 8N1 command receiver: parses A5/addr/data/checksum packets into
// single-cycle configuration register writes.
module energy_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rxd,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       chk_err,
    output logic       busy
);

    localparam int unsigned HalfBit       = CLKS_PER_BIT / 2;
    localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CntW          = $clog2(CLKS_PER_BIT);
    localparam int unsigned ToW           = $clog2(TimeoutCycles + 1);
    localparam logic [7:0]  SyncByte      = 8'hA5;

    typedef enum logic [1:0] {BitIdle, BitStart, BitData, BitStop} bit_state_e;
    typedef enum logic [1:0] {PSync, PAddr, PData, PChk} parse_state_e;

    logic            rx_meta_q, rxs_q;
    bit_state_e      bit_state_q, bit_state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_stb_q, byte_stb_d;
    logic            frame_err_q, frame_err_d;

    parse_state_e    parse_q, parse_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            wr_en_q, wr_en_d;
    logic            chk_err_q, chk_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // Bit engine: byte strobe and frame error are registered one cycle after the stop sample.
    always_comb begin
        bit_state_d = bit_state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (bit_state_q)
            BitIdle: begin
                if (!rxs_q) begin
                    bit_state_d = BitStart;
                    bit_cnt_d   = '0;
                end
            end
            BitStart: begin
                if (bit_cnt_q == CntW'(HalfBit - 1)) begin
                    bit_cnt_d   = '0;
                    bit_idx_d   = '0;
                    bit_state_d = rxs_q ? BitIdle : BitData;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            BitData: begin
                if (bit_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_d = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_state_d = BitStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            BitStop: begin
                if (bit_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_d   = '0;
                    bit_state_d = BitIdle;
                    byte_stb_d  = rxs_q;
                    frame_err_d = !rxs_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        endcase
        if (!ena) begin
            bit_state_d = BitIdle;
            bit_cnt_d   = '0;
            bit_idx_d   = '0;
            byte_stb_d  = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_state_q <= BitIdle;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_state_q <= bit_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Packet parser; a byte strobe takes priority over a coincident timeout expiry.
    always_comb begin
        parse_d   = parse_q;
        to_cnt_d  = to_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        chk_err_d = 1'b0;
        if (frame_err_q) begin
            parse_d  = PSync;
            to_cnt_d = '0;
        end else if (byte_stb_q) begin
            to_cnt_d = '0;
            unique case (parse_q)
                PSync: if (shift_q == SyncByte) parse_d = PAddr;
                PAddr: begin
                    addr_d  = shift_q;
                    parse_d = PData;
                end
                PData: begin
                    data_d  = shift_q;
                    parse_d = PChk;
                end
                PChk: begin
                    if (shift_q == (SyncByte ^ addr_q ^ data_q)) begin
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                        wr_en_d   = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    parse_d = PSync;
                end
            endcase
        end else if (parse_q != PSync && bit_state_q == BitIdle) begin
            if (to_cnt_q == ToW'(TimeoutCycles - 1)) begin
                parse_d  = PSync;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
        if (!ena) begin
            parse_d   = PSync;
            to_cnt_d  = '0;
            wr_en_d   = 1'b0;
            chk_err_d = 1'b0;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parse_q   <= PSync;
            to_cnt_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            parse_q   <= parse_d;
            to_cnt_q  <= to_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign chk_err   = chk_err_q;
    assign busy      = (bit_state_q != BitIdle) || (parse_q != PSync);

endmodule
